// File: rtl/pipe_hazard_ctrl.sv
// Run/halt sequencing, RAW/load-use hazard detection and EXE forwarding selects for the 5-stage core.
// Optional macro PIPE_FWD_EN enables operand forwarding; without it every RAW hazard stalls.
module pipe_hazard_ctrl #(
  parameter int RFW = 5,
  parameter int SCW = 16,
  parameter int DRN = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           id_valid,
  input  logic [RFW-1:0] id_rs1,
  input  logic [RFW-1:0] id_rs2,
  input  logic           id_rs1_used,
  input  logic           id_rs2_used,
  input  logic [RFW-1:0] id_rd,
  input  logic           id_we,
  input  logic           id_load,
  input  logic           id_halt,
  input  logic           exe_br_taken,
  output logic           pc_clr,
  output logic           pc_en,
  output logic           pc_sel,
  output logic           if_id_en,
  output logic           if_id_flush,
  output logic           id_exe_flush,
  output logic [1:0]     fwd_a,
  output logic [1:0]     fwd_b,
  output logic           busy,
  output logic [SCW-1:0] stall_cnt
);

  localparam int DCW = $clog2(DRN + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_HALTED} state_t;

  typedef struct packed {
    logic           v;
    logic [RFW-1:0] rd;
    logic           we;
    logic           load;
  } sb_t;

  state_t         state, state_n;
  logic [DCW-1:0] drain_cnt, drain_n;
  sb_t            sb_ex, sb_mem, sb_wb;
  logic           enter_ex, stall, stall_raw;
  logic           m1_ex, m1_mem, m1_wb, m2_ex, m2_mem, m2_wb;

  function automatic logic sb_match(input sb_t s, input logic [RFW-1:0] r, input logic used);
    return s.v & s.we & (s.rd == r) & (r != '0) & used;
  endfunction

  function automatic logic [SCW-1:0] sat_inc(input logic [SCW-1:0] c);
    return (&c) ? c : c + SCW'(1);
  endfunction

  always_comb begin
    m1_ex  = id_valid & sb_match(sb_ex,  id_rs1, id_rs1_used);
    m1_mem = id_valid & sb_match(sb_mem, id_rs1, id_rs1_used);
    m1_wb  = id_valid & sb_match(sb_wb,  id_rs1, id_rs1_used);
    m2_ex  = id_valid & sb_match(sb_ex,  id_rs2, id_rs2_used);
    m2_mem = id_valid & sb_match(sb_mem, id_rs2, id_rs2_used);
    m2_wb  = id_valid & sb_match(sb_wb,  id_rs2, id_rs2_used);
`ifdef PIPE_FWD_EN
    stall_raw = (m1_ex | m2_ex) & sb_ex.load;
`else
    stall_raw = m1_ex | m1_mem | m1_wb | m2_ex | m2_mem | m2_wb;
`endif
    stall = (state == S_RUN) & stall_raw;
  end

  always_comb begin
    state_n      = state;
    drain_n      = drain_cnt;
    enter_ex     = 1'b0;
    pc_clr       = 1'b0;
    pc_en        = 1'b0;
    pc_sel       = 1'b0;
    if_id_en     = 1'b0;
    if_id_flush  = 1'b0;
    id_exe_flush = 1'b0;
    busy         = (state == S_RUN) || (state == S_DRAIN);
    case (state)
      S_IDLE, S_HALTED: begin
        if (start) begin
          pc_clr  = 1'b1;
          state_n = S_RUN;
        end
      end
      S_RUN: begin
        if (exe_br_taken) begin
          pc_sel       = 1'b1;
          pc_en        = 1'b1;
          if_id_flush  = 1'b1;
          id_exe_flush = 1'b1;
        end else if (stall) begin
          id_exe_flush = 1'b1;
        end else if (id_valid && id_halt) begin
          // HALT goes down the pipe as a bubble; fetch freezes from here on.
          id_exe_flush = 1'b1;
          state_n      = S_DRAIN;
          drain_n      = DCW'(DRN - 1);
        end else begin
          pc_en    = 1'b1;
          if_id_en = 1'b1;
          enter_ex = id_valid;
        end
      end
      S_DRAIN: begin
        if (exe_br_taken) begin
          // A taken branch older than HALT means HALT was on the wrong path.
          pc_sel       = 1'b1;
          pc_en        = 1'b1;
          if_id_flush  = 1'b1;
          id_exe_flush = 1'b1;
          state_n      = S_RUN;
        end else begin
          id_exe_flush = 1'b1;
          if (drain_cnt == '0) state_n = S_HALTED;
          else                 drain_n = drain_cnt - DCW'(1);
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

`ifdef PIPE_FWD_EN
  function automatic logic [1:0] fwd_sel(input logic m_ex, input logic m_mem, input logic m_wb);
    if (m_ex)  return 2'b01;
    if (m_mem) return 2'b10;
    if (m_wb)  return 2'b11;
    return 2'b00;
  endfunction

  // ID -> EXE boundary: selects travel with the instruction into ID_EXE
  always_ff @(posedge clk) begin
    if (rst) begin
      fwd_a <= 2'b00;
      fwd_b <= 2'b00;
    end else begin
      fwd_a <= enter_ex ? fwd_sel(m1_ex, m1_mem, m1_wb) : 2'b00;
      fwd_b <= enter_ex ? fwd_sel(m2_ex, m2_mem, m2_wb) : 2'b00;
    end
  end
`else
  assign fwd_a = 2'b00;
  assign fwd_b = 2'b00;
`endif

  // Scoreboard shadows EXE/MEM/WB, advancing one stage per active cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      drain_cnt <= '0;
      sb_ex     <= '0;
      sb_mem    <= '0;
      sb_wb     <= '0;
      stall_cnt <= '0;
    end else begin
      state     <= state_n;
      drain_cnt <= drain_n;
      if ((state == S_IDLE || state == S_HALTED) && start) begin
        sb_ex  <= '0;
        sb_mem <= '0;
        sb_wb  <= '0;
      end else if (state == S_RUN || state == S_DRAIN) begin
        sb_wb  <= sb_mem;
        sb_mem <= sb_ex;
        sb_ex  <= enter_ex ? sb_t'{1'b1, id_rd, id_we, id_load} : '0;
      end
      if (stall && !exe_br_taken) stall_cnt <= sat_inc(stall_cnt);
    end
  end

endmodule
